// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered N_CH-to-1 multiplexer with valid/ready on every
// input and on the output. Channel choice is either the external sel
// (fixed mode) or a round-robin scan starting at an internal pointer.
// A one-entry output buffer gives 1-cycle latency at full throughput.
// Optional build macro MUX_RR_STATS_EN adds a saturating 16-bit count
// of output transfers on port xfer_cnt.
module mux_rr_reg #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] x,
  input  logic [N_CH-1:0]   x_valid,
  output logic [N_CH-1:0]   x_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      m,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [SELW-1:0]   m_ch
`ifdef MUX_RR_STATS_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e          state_q, state_d;
  logic [W-1:0]        m_q, m_d;
  logic [SELW-1:0]     m_ch_q, m_ch_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic [SELW-1:0]     g;
  logic                granted;
  logic [W-1:0]        g_data;
  logic                load_en;

  // Buffer can take a word when empty or when the held word drains this cycle.
  assign load_en = (state_q == EMPTY) | m_ready;

  // Grant selection: fixed uses sel if in range; round-robin scans from ptr
  // upward first, then wraps to the channels below ptr.
  always_comb begin
    g       = '0;
    granted = 1'b0;
    if (!mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SELW'(i)) begin
          g       = sel;
          granted = x_valid[i];
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!granted && x_valid[i] && (SELW'(i) >= ptr_q)) begin
          granted = 1'b1;
          g       = SELW'(i);
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!granted && x_valid[i] && (SELW'(i) < ptr_q)) begin
          granted = 1'b1;
          g       = SELW'(i);
        end
      end
    end
  end

  // Data of the granted channel and the one-hot accept toward the producers;
  // accepts are forced low while reset is asserted.
  always_comb begin
    g_data  = '0;
    x_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (g == SELW'(i)) begin
        g_data     = x[i*W +: W];
        x_ready[i] = load_en & granted & rst_n;
      end
    end
  end

  // Next state of the output buffer and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    m_ch_d  = m_ch_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (granted) begin
        state_d = FULL;
        m_d     = g_data;
        m_ch_d  = g;
        if (mode) begin
          ptr_d = (g == SELW'(N_CH - 1)) ? '0 : g + SELW'(1);
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Buffer, channel tag and pointer registers; reset discards held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      m_ch_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      m_ch_q  <= m_ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign m       = m_q;
  assign m_ch    = m_ch_q;
  assign m_valid = (state_q == FULL);

`ifdef MUX_RR_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next count: one more per output transfer, sticking at all-ones.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (m_valid && m_ready) begin
      xfer_cnt_d = sat_inc16(xfer_cnt_q);
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed testbench for mux_rr_reg (N_CH=4, W=8).
module tb_mux_rr_reg;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] x;
  logic [N_CH-1:0]   x_valid;
  logic [N_CH-1:0]   x_ready;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [W-1:0]      m;
  logic              m_valid;
  logic              m_ready;
  logic [SELW-1:0]   m_ch;
`ifdef MUX_RR_STATS_EN
  logic [15:0]       xfer_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mux_rr_reg #(.N_CH(N_CH), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .mode    (mode),
    .sel     (sel),
    .m       (m),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_ch    (m_ch)
`ifdef MUX_RR_STATS_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    x       = 32'h44_33_22_11;
    x_valid = 4'b1111;
    mode    = 1'b1;
    sel     = 2'd0;
    m_ready = 1'b1;

    // Reset state with inputs active
    #2;
    chk("rst_m", 32'(m), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_ch", 32'(m_ch), 32'h0);
    chk("rst_x_ready", 32'(x_ready), 32'h0);

    // Fixed mode, sel=2
    #10;
    mode  = 1'b0;
    sel   = 2'd2;
    rst_n = 1'b1;
    #1;
    chk("fix_x_ready", 32'(x_ready), 32'h4);
    tick();
    chk("fix_m", 32'(m), 32'h33);
    chk("fix_m_ch", 32'(m_ch), 32'h2);
    chk("fix_m_valid", 32'(m_valid), 32'h1);

    // Round-robin fairness, ptr still 0 after fixed mode
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_x_ready_%0d", k), 32'(x_ready), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr_m_ch_%0d", k), 32'(m_ch), 32'(k % 4));
      chk($sformatf("rr_m_%0d", k), 32'(m), 32'(((k % 4) + 1) * 8'h11));
      chk($sformatf("rr_m_valid_%0d", k), 32'(m_valid), 32'h1);
    end

    // Skip and wrap: move ptr to 3 via channel 2
    x_valid = 4'b0100;
    tick();
    chk("sw_pre_m_ch", 32'(m_ch), 32'h2);
    x_valid = 4'b0010;
    #1;
    chk("sw_skip_x_ready", 32'(x_ready), 32'h2);
    tick();
    chk("sw_skip_m", 32'(m), 32'h22);
    chk("sw_skip_m_ch", 32'(m_ch), 32'h1);
    x_valid = 4'b0100;
    tick();
    x_valid = 4'b1000;
    tick();
    chk("sw_wrap_m", 32'(m), 32'h44);
    chk("sw_wrap_m_ch", 32'(m_ch), 32'h3);
    x_valid = 4'b1111;
    #1;
    chk("sw_ptr0_x_ready", 32'(x_ready), 32'h1);
    tick();
    chk("sw_ptr0_m_ch", 32'(m_ch), 32'h0);

    // Backpressure: hold 0x22 while inputs churn
    x_valid = 4'b0010;
    tick();
    chk("bp_load_m", 32'(m), 32'h22);
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x       = 32'hA4A3A2A1 + 32'(k);
      x_valid = 4'(k + 5);
      mode    = k[0];
      sel     = 2'(k);
      #1;
      chk($sformatf("bp_x_ready_%0d", k), 32'(x_ready), 32'h0);
      tick();
      chk($sformatf("bp_m_%0d", k), 32'(m), 32'h22);
      chk($sformatf("bp_m_valid_%0d", k), 32'(m_valid), 32'h1);
      chk($sformatf("bp_m_ch_%0d", k), 32'(m_ch), 32'h1);
    end
    x       = 32'h44_33_22_11;
    x_valid = 4'b1111;
    mode    = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("bp_release_x_ready", 32'(x_ready), 32'h4);
    tick();
    chk("bp_release_m", 32'(m), 32'h33);
    chk("bp_release_m_ch", 32'(m_ch), 32'h2);
    chk("bp_release_m_valid", 32'(m_valid), 32'h1);

    // Fixed mode with selected channel idle: no grant, buffer drains
    mode    = 1'b0;
    sel     = 2'd2;
    x_valid = 4'b1011;
    #1;
    chk("nogrant_x_ready", 32'(x_ready), 32'h0);
    tick();
    chk("nogrant_m_valid", 32'(m_valid), 32'h0);
    chk("nogrant_m_hold", 32'(m), 32'h33);
    chk("nogrant_m_ch_hold", 32'(m_ch), 32'h2);

    // Reset while FULL and stalled; ptr (currently 3) returns to 0
    sel     = 2'd1;
    x_valid = 4'b1111;
    tick();
    chk("mid_full_m", 32'(m), 32'h22);
    m_ready = 1'b0;
    mode    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m", 32'(m), 32'h0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_m_ch", 32'(m_ch), 32'h0);
    chk("mid_rst_x_ready", 32'(x_ready), 32'h0);
    #2;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("post_rst_x_ready", 32'(x_ready), 32'h1);
    tick();
    chk("post_rst_m_ch", 32'(m_ch), 32'h0);
    chk("post_rst_m", 32'(m), 32'h11);

`ifdef MUX_RR_STATS_EN
    // One load already done with no output transfer yet; 5 more edges each transfer
    chk("stats_init", 32'(xfer_cnt), 32'h0);
    for (int k = 0; k < 5; k++) tick();
    chk("stats_cnt5", 32'(xfer_cnt), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised, registered N-channel W-bit multiplexer with valid/ready handshake on every input and on the output.
- Successor to the team's 4:1 combinational select mux.
- Two selection modes: fixed (external select, like the 4:1 mux) and round-robin (fair scan over valid channels).
- Sits between multiple producers and one consumer; one-entry output buffer, 1-cycle latency, full throughput.

Parameters:
- N_CH, 4, number of input channels (>=2).
- W, 8, data width per channel.
- SELW, $clog2(N_CH), select/channel-index width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- x  in  N_CH*W  packed channel data; channel i occupies x[i*W +: W].
- x_valid  in  N_CH  per-channel data valid.
- x_ready  out  N_CH  per-channel accept; at most one bit high per cycle.
- mode  in  1  selection mode: 0 = fixed (use sel), 1 = round-robin.
- sel  in  SELW  channel index used when mode=0.
- m  out  W  registered output data.
- m_valid  out  1  output data valid.
- m_ready  in  1  consumer accept.
- m_ch  out  SELW  index of the channel that supplied m.

Behaviour:
- Reset (async on rst_n low): m=0, m_valid=0, m_ch=0, rr pointer ptr=0. Held data is discarded. x_ready is 0 while rst_n is low.
- Output buffer has two states:
  - EMPTY: m_valid=0.
  - FULL: m_valid=1.
- load_en = !m_valid | m_ready. The buffer can accept a new word when it is empty or is being drained this cycle.
- Grant is combinational from current inputs:
  - mode=0: g=sel; granted iff sel<N_CH and x_valid[sel].
  - mode=1: g = first i with x_valid[i]=1, scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1. Granted iff any x_valid bit is set.
- x_ready[g] = load_en & granted. All other x_ready bits are 0. x_ready never depends on x_valid of the same channel except through the grant.
- Input transfer: x_valid[g] & x_ready[g]. On the next clock edge:
  - m <= x[g], m_ch <= g, m_valid <= 1.
  - mode=1 only: ptr <= (g==N_CH-1) ? 0 : g+1.
- load_en with no grant: m_valid <= 0 (EMPTY). m and m_ch hold their last values.
- No load_en (FULL, m_ready=0): m, m_ch and m_valid all hold. Output is stable while stalled.
- Latency: 1 cycle from input transfer to m_valid. Throughput: 1 word/cycle when m_ready is held high.
- Simultaneous drain and load: the new word replaces the old in the same edge; there is no bubble.
- Fixed mode:
  - ptr is not updated.
  - sel out of range (>=N_CH) gives no grant and all x_ready=0.
  - Changing sel while FULL does not alter m.
- Mode switch takes effect on the next grant evaluation. ptr keeps its value across mode switches.
- Fairness (mode=1): with all channels continuously valid and m_ready=1, the grant order is 0,1,…,N_CH-1,0,…. A channel waits at most N_CH-1 transfers.

Optional Feature:
- Macro: MUX_RR_STATS_EN.
- With macro defined: adds output port xfer_cnt (out, 16 bits), the count of output transfers (m_valid & m_ready).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Without macro: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: apply rst_n=0 mid-transfer with m_valid=1 -> m=0, m_valid=0, m_ch=0, x_ready=0 immediately; after release, first rr grant goes to channel 0.
- Fixed mode: N_CH=4, W=8, mode=0, sel=2, x=0x44_33_22_11, all x_valid=1, m_ready=1 -> x_ready=4'b0100, next cycle m=0x33, m_ch=2, m_valid=1.
- Round-robin fairness: mode=1, all x_valid=1, m_ready=1 for 8 cycles -> m_ch sequence 0,1,2,3,0,1,2,3; m follows 0x11,0x22,0x33,0x44 repeating.
- Skip and wrap: mode=1, ptr=3, x_valid=4'b0010 -> grant channel 1, m=0x22, ptr becomes 2. Then ptr=3, x_valid=4'b1000 -> grant 3, ptr wraps to 0.
- Backpressure: FULL with m=0x22, m_ready=0 for 3 cycles while inputs change -> m=0x22 held, x_ready=0. Raise m_ready -> new word loaded the same edge with no bubble.
- Edge cases: mode=0, sel=2, x_valid[2]=0 -> no grant, m_valid drops after drain. With MUX_RR_STATS_EN defined, 5 transfers give xfer_cnt=5.
